// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains a first-word-fall-through FIFO into a valid/ready stream
//            through a 2-entry output buffer, framing words into packets.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int                  c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                r_occ;
    logic [DSIZE-1:0]    r_skid;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_BEAT_W-1:0] w_beat_nxt;
    logic                w_hs;
    logic                w_beat_wrap;
    logic                w_valid_nxt;

    // Pop decision never looks at m_ready, so the FIFO side has no
    // combinational dependency on the downstream consumer.
    assign rinc        = rrst_n && !rempty && en && (r_occ != OCC_TWO);
    assign w_hs        = m_valid && m_ready;
    assign w_beat_wrap = w_hs && (r_beat == c_BEAT_LAST);
    assign w_valid_nxt = rinc || (r_occ == OCC_TWO) || ((r_occ == OCC_ONE) && !w_hs);

    always_comb begin
        w_beat_nxt = r_beat;
        if (w_beat_wrap) begin
            w_beat_nxt = '0;
        end else if (w_hs) begin
            w_beat_nxt = r_beat + 1'b1;
        end
    end

    // The head entry lives directly in m_data; r_skid holds the younger word.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_occ     <= OCC_EMPTY;
            r_skid    <= '0;
            r_beat    <= '0;
            pkt_count <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            r_beat  <= w_beat_nxt;
            m_valid <= w_valid_nxt;
            m_last  <= w_valid_nxt && (w_beat_nxt == c_BEAT_LAST);
            if (w_beat_wrap) begin
                pkt_count <= pkt_count + 1'b1;
            end
            case (r_occ)
                OCC_EMPTY: begin
                    if (rinc) begin
                        m_data <= rdata;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (rinc && w_hs) begin
                        m_data <= rdata;
                    end else if (rinc) begin
                        r_skid <= rdata;
                        r_occ  <= OCC_TWO;
                    end else if (w_hs) begin
                        r_occ <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_hs) begin
                        m_data <= r_skid;
                        r_occ  <= OCC_ONE;
                    end
                end
                default: begin
                    r_occ <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter DSIZE, default 32, giving the data word width and matching the FIFO read port.
REQ-002 The block SHALL have parameter PKT_LEN, default 8, giving the words per packet (legal range 1..65535).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the packet counter.
REQ-004 The block SHALL have port rclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rrst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: enable for new FIFO pops.
REQ-007 The block SHALL have port rempty, input, 1 bit: FIFO empty flag.
REQ-008 The block SHALL have port rdata, input, DSIZE bits: FIFO head word, valid while rempty=0 (first-word-fall-through).
REQ-009 The block SHALL have port rinc, output, 1 bit: FIFO pop strobe.
REQ-010 The block SHALL have port m_valid, output, 1 bit: stream word valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-012 The block SHALL have port m_data, output, DSIZE bits: stream word.
REQ-013 The block SHALL have port m_last, output, 1 bit: final word of the current packet.
REQ-014 The block SHALL have port pkt_count, output, CNT_W bits: number of completed packets.

Function
REQ-015 The block SHALL hold a 2-entry in-order output buffer, with occupancy state EMPTY(0), ONE(1) or TWO(2).
REQ-016 rinc SHALL equal (rempty=0) AND en AND (occupancy<2), decoded from registered state and inputs only, with no path from m_ready.
REQ-017 When rinc=1, rdata SHALL be captured at that rising edge.
REQ-018 A pop at edge N SHALL make the word visible on m_data with m_valid=1 from edge N onward if occupancy was EMPTY (1-cycle latency from rempty falling).
REQ-019 m_valid SHALL be 1 exactly when occupancy is not 0; m_data SHALL show the oldest buffered word.
REQ-020 A handshake SHALL occur when m_valid and m_ready are both 1 at a rising edge; it removes the head word.
REQ-021 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 Occupancy transitions (pop p, handshake h):
- 0: p goes to 1.
- 1: p and not h goes to 2; h and not p goes to 0; p and h stays 1.
- 2: h goes to 1 (p is 0 by REQ-016).
REQ-023 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain one word per cycle.
REQ-024 A beat counter SHALL count handshakes modulo PKT_LEN.
REQ-025 m_last SHALL equal m_valid AND (beat counter = PKT_LEN-1); with PKT_LEN=1, every valid word is last.
REQ-026 A handshake with m_last=1 SHALL clear the beat counter and increment pkt_count, wrapping from 2^CNT_W-1 to 0.
REQ-027 Deasserting en SHALL stop pops only; buffered words SHALL still drain, and the beat and packet counts SHALL be preserved.
REQ-028 If rempty rises while words are buffered, the buffered words SHALL still be delivered; no word SHALL be duplicated, dropped or reordered.

Reset
REQ-029 While rrst_n=0 at a rising edge, the block SHALL set occupancy=0, beat counter=0, pkt_count=0, m_data=0, m_valid=0, m_last=0 and rinc=0.
REQ-030 A reset during operation SHALL discard all buffered words with no further handshakes; the first word after reset SHALL start a new packet.
REQ-031 The first pop SHALL be possible at the first edge after rrst_n returns to 1.

Verification
REQ-032 The bench SHALL cover: write 0..9 to the FIFO, en=1, m_ready=1 -> m_data 0..9 on consecutive cycles; m_last on words 7 only; pkt_count=1.
REQ-033 The bench SHALL cover: 16 words queued, m_ready toggling 1/0 each cycle -> all 16 in order, data stable while stalled, rinc never 1 with occupancy=2, pkt_count=2.
REQ-034 The bench SHALL cover: m_ready=0 for 20 cycles with a full FIFO -> exactly 2 pops, m_data=first word held; then m_ready=1 -> remaining words in order.
REQ-035 The bench SHALL cover: en=0 after 3 pops -> rinc=0, 3 words delivered, then m_valid=0; en=1 -> resumes at word 3 with beat counter continuing.
REQ-036 The bench SHALL cover: rrst_n=0 for 1 cycle with occupancy=2 and beat counter=5 -> m_valid=0, pkt_count=0; the next word delivered has beat counter 0.
REQ-037 The bench SHALL cover: PKT_LEN=1, 4 words -> m_last=1 on every word; pkt_count=4; with CNT_W=2 and 5 packets -> pkt_count=1.
